// File: rtl/lfsr_count_decoder_if.sv
// lfsr_count_decoder_if
//   Handshake bundle between the counter snapshot (master) and the
//   LFSR position decoder (slave).
//   Input channel : in_valid, in_ready, in_code[5:0], in_upper[UPPER_W-1:0]
//   Output channel: out_valid, out_ready, out_idx[5:0],
//                   out_value[UPPER_W+5:0], out_err
//   master : drives the input channel and out_ready, observes results.
//   slave  : the decoder side.
interface lfsr_count_decoder_if #(
   parameter int unsigned UPPER_W = 58
);
   logic                 in_valid;
   logic                 in_ready;
   logic [5:0]           in_code;
   logic [UPPER_W-1:0]   in_upper;
   logic                 out_valid;
   logic                 out_ready;
   logic [5:0]           out_idx;
   logic [UPPER_W+5:0]   out_value;
   logic                 out_err;

   modport master (
      output in_valid, in_code, in_upper, out_ready,
      input  in_ready, out_valid, out_idx, out_value, out_err
   );

   modport slave (
      input  in_valid, in_code, in_upper, out_ready,
      output in_ready, out_valid, out_idx, out_value, out_err
   );
endinterface

// File: rtl/lfsr_count_decoder.sv
// lfsr_count_decoder
//   Converts a hybrid counter word ({binary upper field, 6-bit LFSR low
//   field}) into a plain binary position:
//      out_value = in_upper*63 + index(in_code)
//   The LFSR is x^6+x^5+1, seed 6'h3F at index 0, period 63.
//   Step: q0'=q5, q1'=q0, q2'=q1, q3'=q2, q4'=q3, q5'=q4^q5.
//
//   Ports:
//     clk   - clock, rising edge
//     nrst  - asynchronous active-low reset
//     bus   - lfsr_count_decoder_if.slave (valid/ready in and out channels)
//
//   Configuration:
//     LFSR_DEC_LUT_EN - when defined, the iterative walker is replaced by a
//                       combinational code->index lookup; every code then
//                       completes one cycle after accept. Undefined (default)
//                       gives the walker with index+1 cycles of latency.
//
//   Flow: IDLE accepts a word, SEARCH resolves the index, DONE holds the
//   registered result until out_ready. in_ready is decoded from state; all
//   other outputs are registered.
module lfsr_count_decoder #(
   parameter int unsigned UPPER_W = 58
) (
   input  logic                 clk,
   input  logic                 nrst,
   lfsr_count_decoder_if.slave  bus
);

   localparam int unsigned VW = UPPER_W + 6;
   localparam logic [5:0]  SEED = 6'h3F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [5:0]         code_q, code_d;
   logic [UPPER_W-1:0] upper_q, upper_d;
   logic               valid_q, valid_d;
   logic [5:0]         idx_q, idx_d;
   logic [VW-1:0]      value_q, value_d;
   logic               err_q, err_d;
`ifndef LFSR_DEC_LUT_EN
   logic [5:0]         walker_q, walker_d;
   logic [5:0]         cnt_q, cnt_d;
`endif

   // One LFSR step, bit order {q5..q0}.
   function automatic logic [5:0] lfsr_step(input logic [5:0] s);
      return {s[4] ^ s[5], s[3:0], s[5]};
   endfunction

   // upper*63 + idx as (upper<<6) - upper + idx at full output width;
   // the maximum upper plus idx 62 still fits in UPPER_W+6 bits.
   function automatic logic [VW-1:0] compose(input logic [UPPER_W-1:0] up,
                                             input logic [5:0] idx);
      logic [VW-1:0] wide;
      wide = {6'b0, up};
      return (wide << 6) - wide + {{UPPER_W{1'b0}}, idx};
   endfunction

`ifdef LFSR_DEC_LUT_EN
   // Unrolled walk of the whole sequence; folds into a 63-entry table.
   function automatic logic [5:0] lut_index(input logic [5:0] code);
      logic [5:0] w;
      logic [5:0] idx;
      w   = SEED;
      idx = '0;
      for (int unsigned k = 0; k < 63; k++) begin
         if (w == code) idx = 6'(k);
         w = lfsr_step(w);
      end
      return idx;
   endfunction
`endif

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      upper_d  = upper_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      value_d  = value_q;
      err_d    = err_q;
`ifndef LFSR_DEC_LUT_EN
      walker_d = walker_q;
      cnt_d    = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               code_d   = bus.in_code;
               upper_d  = bus.in_upper;
`ifndef LFSR_DEC_LUT_EN
               walker_d = SEED;
               cnt_d    = '0;
`endif
               state_d  = ST_SEARCH;
            end
         end

         ST_SEARCH: begin
            if (code_q == 6'h00) begin
               // Lock-up state never appears in the sequence; flag it
               // immediately rather than walking a full period.
               err_d   = 1'b1;
               idx_d   = '0;
               value_d = '0;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
`ifdef LFSR_DEC_LUT_EN
            else begin
               err_d   = 1'b0;
               idx_d   = lut_index(code_q);
               value_d = compose(upper_q, lut_index(code_q));
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
`else
            else if (walker_q == code_q) begin
               err_d   = 1'b0;
               idx_d   = cnt_q;
               value_d = compose(upper_q, cnt_q);
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               walker_d = lfsr_step(walker_q);
               cnt_d    = cnt_q + 6'd1;
            end
`endif
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         upper_q  <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         value_q  <= '0;
         err_q    <= 1'b0;
`ifndef LFSR_DEC_LUT_EN
         walker_q <= SEED;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         upper_q  <= upper_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         value_q  <= value_d;
         err_q    <= err_d;
`ifndef LFSR_DEC_LUT_EN
         walker_q <= walker_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_value = value_q;
   assign bus.out_err   = err_q;

endmodule

// File: tb/tb_lfsr_count_decoder.sv
// tb_lfsr_count_decoder
//   Scoreboarded bench for lfsr_count_decoder: each accepted word pushes
//   its expected index/value/err/latency; the result is popped and compared
//   when out_valid is seen.
module tb_lfsr_count_decoder;

   localparam int unsigned UPPER_W = 58;

   typedef struct {
      logic [5:0]  idx;
      logic [63:0] value;
      logic        err;
      int unsigned lat;
   } exp_t;

   logic clk;
   logic nrst;
   int unsigned n_checks;
   int unsigned n_errors;
   exp_t sb[$];

   lfsr_count_decoder_if #(.UPPER_W(UPPER_W)) bus ();

   lfsr_count_decoder #(.UPPER_W(UPPER_W)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference index: walk the sequence from the seed.
   function automatic logic [5:0] ref_index(input logic [5:0] code);
      logic [5:0] s;
      s = 6'h3F;
      for (int k = 0; k < 63; k++) begin
         if (s == code) return 6'(k);
         s = {s[5] ^ s[4], s[3], s[2], s[1], s[0], s[5]};
      end
      return 6'd0;
   endfunction

   function automatic exp_t model(input logic [5:0] code, input logic [UPPER_W-1:0] upper);
      exp_t e;
      if (code == 6'h00) begin
         e.idx = 6'd0; e.value = 64'd0; e.err = 1'b1;
      end else begin
         e.idx   = ref_index(code);
         e.value = 64'(upper) * 64'd63 + 64'(e.idx);
         e.err   = 1'b0;
      end
`ifdef LFSR_DEC_LUT_EN
      e.lat = 1;
`else
      e.lat = (code == 6'h00) ? 1 : int'(e.idx) + 1;
`endif
      return e;
   endfunction

   task automatic check_reset_values();
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_idx", 64'(bus.out_idx), 64'd0);
      check("rst_value", bus.out_value, 64'd0);
      check("rst_err", 64'(bus.out_err), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic run_decode(input logic [5:0] code, input logic [UPPER_W-1:0] upper,
                             input int unsigned hold);
      exp_t e;
      int unsigned n;
      bus.in_code  = code;
      bus.in_upper = upper;
      bus.in_valid = 1'b1;
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      // Garbage on the inputs while busy must be ignored.
      bus.in_code  = ~code;
      bus.in_upper = ~upper;
      sb.push_back(model(code, upper));
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) begin
         check("timeout_out_valid", 64'(bus.out_valid), 64'd1);
         sb.delete();
         return;
      end
      e = sb.pop_front();
      check("latency", 64'(n), 64'(e.lat));
      check("idx", 64'(bus.out_idx), 64'(e.idx));
      check("value", bus.out_value, e.value);
      check("err", 64'(bus.out_err), 64'(e.err));
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_idx", 64'(bus.out_idx), 64'(e.idx));
         check("hold_value", bus.out_value, e.value);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("valid_drop", 64'(bus.out_valid), 64'd0);
      check("in_ready_back", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic seen_valid;
      n_checks = 0;
      n_errors = 0;
      nrst          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_code   = '0;
      bus.in_upper  = '0;
      bus.out_ready = 1'b0;
      #2;
      check_reset_values();
      repeat (3) @(posedge clk);
      #2 nrst = 1'b1;
      @(posedge clk); #1;

      run_decode(6'h3F, '0, 0);
      run_decode(6'h1F, 58'd1, 0);
      run_decode(6'h3E, 58'd5, 0);
      run_decode(6'h1D, 58'h123_4567_89AB, 0);
      run_decode(6'h2F, '1, 10);
      run_decode(6'h00, 58'd123, 0);
      for (int i = 0; i < 6; i++) begin
         logic [5:0] c;
         logic [UPPER_W-1:0] u;
         c = 6'($urandom_range(1, 63));
         u = UPPER_W'({$urandom, $urandom});
         run_decode(c, u, $urandom_range(0, 3));
      end

      // Reset in the middle of a long search.
      bus.in_code  = 6'h2F;
      bus.in_upper = 58'd77;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      sb.push_back(model(6'h2F, 58'd77));
      repeat (20) @(posedge clk);
      #3 nrst = 1'b0;
      #1;
      check_reset_values();
      sb.delete();
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      bus.out_ready = 1'b1;
      seen_valid = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         seen_valid = seen_valid | bus.out_valid;
      end
      bus.out_ready = 1'b0;
      check("no_valid_after_reset", 64'(seen_valid), 64'd0);
      run_decode(6'h3F, 58'd9, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
